// File: rtl/i2c_tx_push_arbiter.sv
// i2c_tx_push_arbiter: shares the TX FIFO push port between NREQ requesters in round-robin bursts
// and mirrors the FIFO fill level. Define I2C_TXARB_PRIO_EN to give requester 0 fixed priority.
module i2c_tx_push_arbiter #(
   parameter int NREQ  = 2,
   parameter int DEPTH = 8,
   parameter int LVL_W = 4
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              arb_en,
   input  logic [3:0]        burst_len,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*9-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   input  logic              tx_pop,
   output logic              tx_push,
   output logic [8:0]        tx_push_data,
   output logic [LVL_W-1:0]  tx_level,
   output logic              tx_full,
   output logic [1:0]        grant_id
);

   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_BURST = 1'b1;
   localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEPTH);
`ifdef I2C_TXARB_PRIO_EN
   localparam logic [NREQ-1:0]  REQ0_MASK = NREQ'(1);
`endif

   logic [0:0]       state, state_next;
   logic [1:0]       owner, owner_next;
   logic [1:0]       rr_ptr, rr_ptr_next;
   logic [4:0]       burst_cnt, burst_cnt_next;
   logic [LVL_W-1:0] level, level_next;
   logic             not_full;
   logic             accept;
   logic             owner_valid;
   logic             burst_done;
   logic [8:0]       accept_data;
   logic [1:0]       pick;
   logic [1:0]       owner_inc;
   logic [1:0]       ptr_on_exit;

   // First valid index at or after start; falls back to the lowest valid index (wrap).
   function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] valid, input logic [1:0] start);
      logic [1:0] lowest;
      logic [1:0] ahead;
      logic       found;
      lowest = '0;
      ahead  = '0;
      found  = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (valid[i]) begin
            lowest = 2'(i);
            if (2'(i) >= start) begin
               ahead = 2'(i);
               found = 1'b1;
            end
         end
      end
      return found ? ahead : lowest;
   endfunction

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      not_full    = level < LVL_MAX;
      req_ready   = '0;
      owner_valid = 1'b0;
      accept_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == 2'(i)) begin
            req_ready[i] = (state == ST_BURST) && not_full;
            owner_valid  = req_valid[i];
            accept_data  = req_data[9*i +: 9];
         end
      end
      accept = |(req_valid & req_ready);
   end

   // A simultaneous accept and pop cancel; a pop of an empty FIFO is ignored.
   always_comb begin
      level_next = level;
      if (accept && !tx_pop) begin
         level_next = level + LVL_W'(1);
      end else if (!accept && tx_pop && level != '0) begin
         level_next = level - LVL_W'(1);
      end
   end

   always_comb begin
      owner_inc = (owner == 2'(NREQ - 1)) ? 2'd0 : owner + 2'd1;
`ifdef I2C_TXARB_PRIO_EN
      if (req_valid[0]) begin
         pick = 2'd0;
      end else begin
         pick = rr_pick(req_valid & ~REQ0_MASK, rr_ptr);
      end
      // The pointer only rotates among the non-priority requesters.
      if (owner == 2'd0) begin
         ptr_on_exit = rr_ptr;
      end else begin
         ptr_on_exit = (owner_inc == 2'd0) ? 2'd1 : owner_inc;
      end
`else
      pick        = rr_pick(req_valid, rr_ptr);
      ptr_on_exit = owner_inc;
`endif
   end

   always_comb begin
      state_next     = state;
      owner_next     = owner;
      rr_ptr_next    = rr_ptr;
      burst_cnt_next = burst_cnt;
      burst_done     = 1'b0;
      if (state == ST_IDLE) begin
         if (arb_en && (|req_valid) && not_full) begin
            state_next     = ST_BURST;
            owner_next     = pick;
            burst_cnt_next = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
         end
      end else begin
         if (accept) begin
            burst_cnt_next = burst_cnt - 5'd1;
         end
         burst_done = (accept && burst_cnt == 5'd1) || !owner_valid ||
                      (level_next == LVL_MAX) || !arb_en;
`ifdef I2C_TXARB_PRIO_EN
         if (owner != 2'd0 && req_valid[0]) begin
            burst_done = 1'b1;
         end
`endif
         if (burst_done) begin
            state_next  = ST_IDLE;
            rr_ptr_next = ptr_on_exit;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state        <= ST_IDLE;
         owner        <= '0;
         rr_ptr       <= '0;
         burst_cnt    <= '0;
         level        <= '0;
         tx_push      <= 1'b0;
         tx_push_data <= '0;
      end else begin
         state     <= state_next;
         owner     <= owner_next;
         rr_ptr    <= rr_ptr_next;
         burst_cnt <= burst_cnt_next;
         level     <= level_next;
         tx_push   <= accept;
         if (accept) begin
            tx_push_data <= accept_data;
         end
      end
   end

   assign tx_level = level;
   assign tx_full  = (level == LVL_MAX);
   assign grant_id = owner;

endmodule

// File: tb/tb_i2c_tx_push_arbiter.sv
// Self-checking bench for i2c_tx_push_arbiter: table-driven burst scenarios plus hand-written
// corner sequences, with a push scoreboard and an independent FIFO level model.
module tb_i2c_tx_push_arbiter;

   logic        pclk;
   logic        presetn;
   logic        arb_en;
   logic [3:0]  burst_len;
   logic [1:0]  req_valid;
   logic [17:0] req_data;
   logic [1:0]  req_ready;
   logic        tx_pop;
   logic        tx_push;
   logic [8:0]  tx_push_data;
   logic [3:0]  tx_level;
   logic        tx_full;
   logic [1:0]  grant_id;

   i2c_tx_push_arbiter #(.NREQ(2), .DEPTH(8), .LVL_W(4)) dut (
      .pclk         (pclk),
      .presetn      (presetn),
      .arb_en       (arb_en),
      .burst_len    (burst_len),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .tx_pop       (tx_pop),
      .tx_push      (tx_push),
      .tx_push_data (tx_push_data),
      .tx_level     (tx_level),
      .tx_full      (tx_full),
      .grant_id     (grant_id)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Scenario record; window lists are packed with entry 0 in the least significant slot.
   typedef struct packed {
      logic [3:0]      bl;
      logic [4:0]      n0;
      logic [4:0]      n1;
      logic [3:0]      npop;
      logic [4:0]      exp_push;
      logic [3:0]      exp_lvl;
      logic [2:0]      nwin;
      logic [3:0][1:0] wo;
      logic [3:0][4:0] wl;
   } vec_t;

   vec_t       vecs [5];
   logic [8:0] q0 [$];
   logic [8:0] q1 [$];
   logic [8:0] sb [$];
   int         win_owner [$];
   int         win_len [$];
   int         checks = 0;
   int         errors = 0;
   int         lvl_m, pops_left, push_cnt, serial, drop_en_at;
   int         acc_cnt [2];
   int         cur_owner, cur_len;
   bit         in_win, pop_once, pop_on_acc;
   logic [8:0] last_push_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic load(input int r, input int n);
      for (int k = 0; k < n; k++) begin
         serial++;
         if (r == 0) q0.push_back(9'(serial) ^ 9'h155);
         else        q1.push_back(9'(serial * 3) ^ 9'h0AA);
      end
   endtask

   // One cycle: compare outputs at the falling edge, then drive inputs for the next rising edge.
   task automatic step();
      logic [8:0] exp_data;
      logic [8:0] d0, d1;
      int         acc;
      bit         pop;
      @(negedge pclk);
      if (sb.size() > 0) begin
         exp_data = sb.pop_front();
         check("tx_push", 32'(tx_push), 1);
         check("tx_push_data", 32'(tx_push_data), 32'(exp_data));
      end else begin
         check("tx_push_idle", 32'(tx_push), 0);
      end
      if (tx_push) begin
         push_cnt++;
         last_push_data = tx_push_data;
      end
      check("tx_level", 32'(tx_level), lvl_m);
      check("tx_full", 32'(tx_full), 32'(lvl_m == 8));
      if (req_ready != 2'b00) begin
         check("grant_id", 32'(grant_id), req_ready[1] ? 1 : 0);
         if (!in_win) begin
            in_win    = 1'b1;
            cur_owner = req_ready[1] ? 1 : 0;
            cur_len   = 0;
         end
      end else if (in_win) begin
         win_owner.push_back(cur_owner);
         win_len.push_back(cur_len);
         in_win = 1'b0;
      end
      d0 = (q0.size() > 0) ? q0[0] : 9'h000;
      d1 = (q1.size() > 0) ? q1[0] : 9'h000;
      req_valid = {q1.size() > 0, q0.size() > 0};
      req_data  = {d1, d0};
      acc = -1;
      if (req_valid[0] && req_ready[0]) acc = 0;
      else if (req_valid[1] && req_ready[1]) acc = 1;
      pop = 1'b0;
      if (pops_left > 0 && tx_push) begin
         pop = 1'b1;
         pops_left--;
      end
      if (pop_once) begin
         pop      = 1'b1;
         pop_once = 1'b0;
      end
      if (pop_on_acc && acc >= 0) begin
         pop        = 1'b1;
         pop_on_acc = 1'b0;
      end
      tx_pop = pop;
      if (acc >= 0) begin
         sb.push_back(acc == 0 ? q0.pop_front() : q1.pop_front());
         acc_cnt[acc]++;
         cur_len++;
         if (drop_en_at > 0 && acc_cnt[0] + acc_cnt[1] == drop_en_at) begin
            arb_en     = 1'b0;
            drop_en_at = -1;
         end
      end
      if (acc >= 0 && !pop) lvl_m++;
      else if (acc < 0 && pop && lvl_m > 0) lvl_m--;
   endtask

   task automatic clear_model();
      q0.delete();
      q1.delete();
      sb.delete();
      win_owner.delete();
      win_len.delete();
      lvl_m      = 0;
      pops_left  = 0;
      push_cnt   = 0;
      drop_en_at = -1;
      acc_cnt[0] = 0;
      acc_cnt[1] = 0;
      in_win     = 1'b0;
      pop_once   = 1'b0;
      pop_on_acc = 1'b0;
   endtask

   task automatic do_reset();
      presetn   = 1'b0;
      tx_pop    = 1'b0;
      req_valid = 2'b00;
      req_data  = '0;
      arb_en    = 1'b1;
      clear_model();
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && !in_win) && n < budget) begin
         step();
         n++;
      end
      check(name, 32'(n < budget), 1);
   endtask

   initial begin
      int n;
      int fo;
      presetn   = 1'b0;
      arb_en    = 1'b0;
      burst_len = 4'd4;
      req_valid = 2'b00;
      req_data  = '0;
      tx_pop    = 1'b0;
      serial    = 0;
      last_push_data = '0;
      clear_model();
      #1;
      check("rst_tx_push", 32'(tx_push), 0);
      check("rst_tx_push_data", 32'(tx_push_data), 0);
      check("rst_tx_level", 32'(tx_level), 0);
      check("rst_tx_full", 32'(tx_full), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_req_ready", 32'(req_ready), 0);

      //            bl    n0     n1     npop  push   lvl   nwin  owners {3,2,1,0}      lengths {3,2,1,0}
      vecs[0] = '{4'd4, 5'd6,  5'd6, 4'd4,  5'd12, 4'd8, 3'd4, {2'd1,2'd0,2'd1,2'd0}, {5'd2,5'd2,5'd4,5'd4}};
      vecs[1] = '{4'd0, 5'd3,  5'd2, 4'd0,  5'd5,  4'd5, 3'd2, {2'd0,2'd0,2'd1,2'd0}, {5'd0,5'd0,5'd2,5'd3}};
      vecs[2] = '{4'd1, 5'd2,  5'd2, 4'd0,  5'd4,  4'd4, 3'd4, {2'd1,2'd0,2'd1,2'd0}, {5'd1,5'd1,5'd1,5'd1}};
      vecs[3] = '{4'd3, 5'd10, 5'd0, 4'd2,  5'd10, 4'd8, 3'd4, {2'd0,2'd0,2'd0,2'd0}, {5'd1,5'd3,5'd3,5'd3}};
      vecs[4] = '{4'd0, 5'd18, 5'd0, 4'd10, 5'd18, 4'd8, 3'd2, {2'd0,2'd0,2'd0,2'd0}, {5'd0,5'd0,5'd2,5'd16}};

      for (int v = 0; v < 5; v++) begin
         do_reset();
         burst_len = vecs[v].bl;
         pops_left = int'(vecs[v].npop);
         load(0, int'(vecs[v].n0));
         load(1, int'(vecs[v].n1));
         drain("vec_drain", 400);
         check("vec_push_count", push_cnt, 32'(vecs[v].exp_push));
         check("vec_level", 32'(tx_level), 32'(vecs[v].exp_lvl));
         check("vec_full", 32'(tx_full), 32'(vecs[v].exp_lvl == 4'd8));
`ifndef I2C_TXARB_PRIO_EN
         check("vec_windows", win_owner.size(), 32'(vecs[v].nwin));
         for (int w = 0; w < int'(vecs[v].nwin) && w < win_owner.size(); w++) begin
            check("vec_win_owner", win_owner[w], 32'(vecs[v].wo[w]));
            check("vec_win_len", win_len[w], 32'(vecs[v].wl[w]));
         end
`endif
      end

      // Full FIFO stalls the requester; a single pop admits exactly one more word.
      do_reset();
      burst_len = 4'd0;
      load(0, 8);
      drain("fill_drain", 100);
      check("fill_level", 32'(tx_level), 8);
      load(0, 2);
      for (int k = 0; k < 6; k++) begin
         step();
         check("full_hold_ready", 32'(req_ready), 0);
      end
      check("full_hold_accepts", acc_cnt[0], 8);
      pop_once = 1'b1;
      repeat (8) step();
      check("pop_one_accept", acc_cnt[0], 9);
      check("pop_level", 32'(tx_level), 8);
      check("pop_full", 32'(tx_full), 1);

      // Accept and pop in the same cycle at level 5.
      do_reset();
      burst_len = 4'd0;
      load(0, 5);
      drain("lvl5_drain", 100);
      check("lvl5_level", 32'(tx_level), 5);
      q0.push_back(9'h15A);
      pop_on_acc = 1'b1;
      drain("accpop_drain", 100);
      check("accpop_level", 32'(tx_level), 5);
      check("accpop_data", 32'(last_push_data), 32'h15A);

      // Reset in the middle of requester 1's burst; the regrant starts from requester 0.
      do_reset();
      burst_len = 4'd4;
      load(0, 8);
      load(1, 6);
      n = 0;
      while (acc_cnt[0] + acc_cnt[1] < 6 && n < 60) begin
         step();
         n++;
      end
      check("pre_reset_accepts", acc_cnt[0] + acc_cnt[1], 6);
      @(posedge pclk);
      #1;
      presetn = 1'b0;
      #1;
      check("midrst_tx_push", 32'(tx_push), 0);
      check("midrst_tx_push_data", 32'(tx_push_data), 0);
      check("midrst_tx_level", 32'(tx_level), 0);
      check("midrst_tx_full", 32'(tx_full), 0);
      check("midrst_grant_id", 32'(grant_id), 0);
      check("midrst_req_ready", 32'(req_ready), 0);
      sb.delete();
      win_owner.delete();
      win_len.delete();
      lvl_m  = 0;
      in_win = 1'b0;
      tx_pop = 1'b0;
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      drain("post_reset_drain", 200);
      fo = (win_owner.size() > 0) ? win_owner[0] : -1;
      check("post_reset_first_owner", fo, 0);
      check("post_reset_level", 32'(tx_level), 8);

      // Dropping arb_en lets the current accept finish and then stops all grants.
      do_reset();
      burst_len  = 4'd8;
      drop_en_at = 3;
      load(0, 8);
      n = 0;
      while (acc_cnt[0] < 3 && n < 40) begin
         step();
         n++;
      end
      step();
      for (int k = 0; k < 8; k++) begin
         step();
         check("en_off_ready", 32'(req_ready), 0);
      end
      check("en_off_accepts", acc_cnt[0], 3);
      check("en_off_pushes", push_cnt, 3);
      arb_en = 1'b1;
      drain("en_on_drain", 100);
      check("en_on_pushes", push_cnt, 8);
      check("en_on_level", 32'(tx_level), 8);

`ifdef I2C_TXARB_PRIO_EN
      // Requester 0 rising pre-empts requester 1 after its next accept.
      do_reset();
      burst_len = 4'd8;
      load(1, 4);
      n = 0;
      while (acc_cnt[1] < 2 && n < 40) begin
         step();
         n++;
      end
      load(0, 3);
      drain("prio_drain", 100);
      fo = (win_owner.size() > 1) ? win_owner[1] : -1;
      check("prio_first_owner", (win_owner.size() > 0) ? win_owner[0] : -1, 1);
      check("prio_first_len", (win_len.size() > 0) ? win_len[0] : -1, 3);
      check("prio_second_owner", fo, 0);
      check("prio_level", 32'(tx_level), 7);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
